// File: rtl/small_filt_pkg.sv
// Shared definitions for the small shift-and-add filter family.
// Holds the warm-up state encoding and the width helpers used by both the
// top level and the accumulator core.
package small_filt_pkg;

  // Warm-up progress of a filter instance
  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    WARMUP  = 2'd1,
    SETTLED = 2'd2
  } filt_state_t;

  localparam int FILT_STATE_W = 2;

  // Accumulator width: sample bits plus the fractional bits kept by the
  // feedback shift, so lpf is simply the top WIDTH bits.
  function automatic int filt_acc_width(input int width, input int filt_bits);
    return width + filt_bits;
  endfunction

  // Width of a counter that must hold values 0 .. count-1 (at least one bit)
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage

// File: rtl/small_hpf_core.sv
// Accumulator and difference datapath of the shift-and-add high-pass filter.
// The low-pass state lives in `filter`; its integer part `lpf` is subtracted
// from the incoming sample to form the high-pass difference. The difference
// is combinational; the caller registers it together with the handshake.
// `preload` (only meaningful together with `en`) loads the accumulator with
// the sample itself so the internal low-pass starts at the input level.
module small_hpf_core
  import small_filt_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FILT_BITS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             preload,
  input  logic [WIDTH-1:0] sample,
  output logic [WIDTH:0]   diff
);

  localparam int ACC_W = filt_acc_width(WIDTH, FILT_BITS);

  logic [ACC_W-1:0] filter;
  logic [ACC_W-1:0] filter_next;
  logic [WIDTH-1:0] lpf;

  // Integer part of the low-pass state
  assign lpf = filter[ACC_W-1:FILT_BITS];

  // Both operands zero-extended by one bit: the result spans
  // -(2^WIDTH-1) .. +(2^WIDTH-1) and never needs saturation.
  assign diff = {1'b0, sample} - {1'b0, lpf};

  // Next accumulator value: either a preload to the sample level or the
  // leaky integration filter + sample - lpf (cannot overflow since lpf is
  // bounded by the largest sample).
  always_comb begin
    filter_next = filter + ACC_W'(sample) - ACC_W'(lpf);
    if (preload) begin
      filter_next = ACC_W'(sample) << FILT_BITS;
    end
  end

  // Accumulator register, advancing only on accepted samples
  always_ff @(posedge clk) begin
    if (rst) begin
      filter <= '0;
    end else if (en) begin
      filter <= filter_next;
    end
  end

endmodule

// File: rtl/small_hpf_unsigned.sv
// Single-pole shift-and-add IIR high-pass filter with valid/ready streaming.
// Output = input minus the internal low-pass state, i.e. DC removal.
// The top level owns the single output register (full throughput, no
// combinational inValid -> outValid path) and the warm-up state machine.
// Optional build macro SMALL_HPF_PRELOAD_EN: the first sample after reset
// preloads the low-pass state, produces 0 and marks the filter settled
// immediately, removing the start-up step transient.
module small_hpf_unsigned
  import small_filt_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int FILT_BITS  = 8,
  parameter int SETTLE_CNT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] dataIn,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH:0]   dataOut,
  output logic             settled
);

  localparam int CNT_W = cnt_width(SETTLE_CNT);

  localparam logic [FILT_STATE_W-1:0] ST_EMPTY   = EMPTY;
  localparam logic [FILT_STATE_W-1:0] ST_WARMUP  = WARMUP;
  localparam logic [FILT_STATE_W-1:0] ST_SETTLED = SETTLED;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_CNT - 1);

  logic                    accept;
  logic                    preload;
  logic [WIDTH:0]          diff;
  logic [FILT_STATE_W-1:0] state;
  logic [FILT_STATE_W-1:0] state_next;
  logic [CNT_W-1:0]        counter;
  logic [CNT_W-1:0]        counter_next;

  // A new sample fits whenever the output register is empty or being drained
  assign inReady = !outValid || outReady;
  assign accept  = inValid && inReady;

`ifdef SMALL_HPF_PRELOAD_EN
  assign preload = (state == ST_EMPTY);
`else
  assign preload = 1'b0;
`endif

  small_hpf_core #(
    .WIDTH    (WIDTH),
    .FILT_BITS(FILT_BITS)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .en     (accept),
    .preload(preload),
    .sample (dataIn),
    .diff   (diff)
  );

  // Output register: load on accept, drop valid once consumed, hold otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      dataOut  <= '0;
    end else if (accept) begin
      outValid <= 1'b1;
      dataOut  <= preload ? '0 : diff;
    end else if (outReady) begin
      outValid <= 1'b0;
    end
  end

  // Warm-up sequencing: counts accepted samples until the filter is settled;
  // SETTLED is terminal so the counter freezes instead of wrapping.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    if (accept) begin
      case (state)
        ST_EMPTY: begin
`ifdef SMALL_HPF_PRELOAD_EN
          state_next = ST_SETTLED;
`else
          counter_next = '0;
          if (SETTLE_CNT <= 1) begin
            state_next = ST_SETTLED;
          end else begin
            state_next = ST_WARMUP;
          end
`endif
        end
        ST_WARMUP: begin
          counter_next = counter + 1'b1;
          if (counter_next == LAST_CNT) begin
            state_next = ST_SETTLED;
          end
        end
        ST_SETTLED: begin
          state_next = ST_SETTLED;
        end
        default: begin
          state_next   = ST_EMPTY;
          counter_next = '0;
        end
      endcase
    end
  end

  // State, counter and the registered settled flag (which rises together
  // with outValid of the sample that completes warm-up)
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_EMPTY;
      counter <= '0;
      settled <= 1'b0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
      settled <= (state_next == ST_SETTLED);
    end
  end

endmodule

// File: tb/tb_small_hpf_unsigned.sv
// Self-checking bench for small_hpf_unsigned (WIDTH=8, FILT_BITS=4,
// SETTLE_CNT=3). Works in both builds; SMALL_HPF_PRELOAD_EN selects the
// preload behaviour of the reference model.
module tb_small_hpf_unsigned;

  localparam int WIDTH      = 8;
  localparam int FILT_BITS  = 4;
  localparam int SETTLE_CNT = 3;
`ifdef SMALL_HPF_PRELOAD_EN
  localparam bit PRELOAD = 1'b1;
`else
  localparam bit PRELOAD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             inValid;
  logic             inReady;
  logic [WIDTH-1:0] dataIn;
  logic             outValid;
  logic             outReady;
  logic [WIDTH:0]   dataOut;
  logic             settled;

  int checks   = 0;
  int failures = 0;

  // Reference model: low-pass state as a plain integer, output as a plain
  // signed integer, plus the output register occupancy.
  int m_acc;
  int m_count;
  bit m_valid;
  int m_data;
  bit m_settled;

  always #5 clk = ~clk;

  small_hpf_unsigned #(
    .WIDTH     (WIDTH),
    .FILT_BITS (FILT_BITS),
    .SETTLE_CNT(SETTLE_CNT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .inValid (inValid),
    .inReady (inReady),
    .dataIn  (dataIn),
    .outValid(outValid),
    .outReady(outReady),
    .dataOut (dataOut),
    .settled (settled)
  );

  task automatic model_reset();
    m_acc     = 0;
    m_count   = 0;
    m_valid   = 1'b0;
    m_data    = 0;
    m_settled = 1'b0;
  endtask

  // Advance the model by one clock given the inputs presented this cycle
  task automatic model_clock(input bit v, input int din, input bit r, output bit acc);
    int lpf;
    acc = v && (!m_valid || r);
    if (acc) begin
      lpf = m_acc / (1 << FILT_BITS);
      if (PRELOAD && m_count == 0) begin
        m_acc  = din * (1 << FILT_BITS);
        m_data = 0;
      end else begin
        m_data = din - lpf;
        m_acc  = m_acc + din - lpf;
      end
      m_count++;
      m_valid   = 1'b1;
      m_settled = PRELOAD ? 1'b1 : (m_count >= SETTLE_CNT);
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  // Called at a negedge; leaves the bench at the following negedge
  task automatic apply_reset();
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b1;
    dataIn   = '0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    inValid  = 1'b1;
    outReady = 1'b0;
    dataIn   = 8'd55;
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b0;
    inValid = 1'b0;
    model_reset();
    #1;
    checks++;
    if (outValid !== 1'b0 || settled !== 1'b0 || dataOut !== 9'd0) begin
      failures++;
      $display("[TB] FAIL reset_state outValid=%0b settled=%0b dataOut=%h required 0/0/000",
               outValid, settled, dataOut);
    end
    checks++;
    if (inReady !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_inReady got=%0b required=1", inReady);
    end
    @(negedge clk);
  endtask

  task automatic test_constant();
    int seq[$];
    int viol;
    bit acc;
    logic [WIDTH:0] exp_d;
    apply_reset();
    for (int i = 0; i < 31; i++) begin
      inValid  = 1'b1;
      dataIn   = (i < 30) ? 8'd100 : 8'd0;
      outReady = 1'b1;
      #1;
      exp_d = m_data[WIDTH:0];
      checks++;
      if (outValid !== m_valid || dataOut !== exp_d || settled !== m_settled) begin
        failures++;
        $display("[TB] FAIL constant cyc=%0d valid=%0b data=%h settled=%0b required %0b/%h/%0b",
                 i, outValid, dataOut, settled, m_valid, exp_d, m_settled);
      end
      if (outValid === 1'b1) seq.push_back($signed(dataOut));
      model_clock(1'b1, int'(dataIn), 1'b1, acc);
      @(negedge clk);
    end
    #1;
    exp_d = m_data[WIDTH:0];
    checks++;
    if (dataOut !== exp_d) begin
      failures++;
      $display("[TB] FAIL constant_step got=%h required=%h", dataOut, exp_d);
    end
`ifdef SMALL_HPF_PRELOAD_EN
    checks++;
    if (dataOut !== 9'h19C) begin
      failures++;
      $display("[TB] FAIL preload_step got=%h required=19c", dataOut);
    end
`endif
    inValid = 1'b0;
    checks++;
    if (seq.size() < 2 || seq[0] != (PRELOAD ? 0 : 100) || seq[1] != (PRELOAD ? 0 : 94)) begin
      failures++;
      $display("[TB] FAIL constant_first got=%0d,%0d required=%0d,%0d",
               (seq.size() > 0) ? seq[0] : -999, (seq.size() > 1) ? seq[1] : -999,
               PRELOAD ? 0 : 100, PRELOAD ? 0 : 94);
    end
    viol = 0;
    for (int i = 1; i < seq.size(); i++) begin
      if (seq[i] > seq[i-1] || seq[i] < 0) viol++;
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("[TB] FAIL constant_monotonic violations=%0d required=0", viol);
    end
    @(negedge clk);
  endtask

  task automatic test_extremes();
    bit acc;
    logic [WIDTH:0] exp_d;
    apply_reset();
    for (int i = 0; i < 252; i++) begin
      inValid  = 1'b1;
      dataIn   = (i < 250) ? 8'd255 : 8'd0;
      outReady = 1'b1;
      #1;
      exp_d = m_data[WIDTH:0];
      checks++;
      if (dataOut !== exp_d) begin
        failures++;
        $display("[TB] FAIL extremes cyc=%0d got=%h required=%h", i, dataOut, exp_d);
      end
      if (i == 251) begin
        checks++;
        if (dataOut !== 9'h101) begin
          failures++;
          $display("[TB] FAIL extremes_min got=%h required=101", dataOut);
        end
      end
      model_clock(1'b1, int'(dataIn), 1'b1, acc);
      @(negedge clk);
    end
    inValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [WIDTH:0] exp_d;
    logic [WIDTH:0] held;
    apply_reset();
    for (int i = 0; i < 27; i++) begin
      inValid  = 1'b1;
      dataIn   = WIDTH'($urandom_range(0, 255));
      outReady = (i >= 1 && i <= 5) ? 1'b0 : ((i == 0) ? 1'b0 : 1'b1);
      #1;
      exp_d = m_data[WIDTH:0];
      checks++;
      if (outValid !== m_valid || dataOut !== exp_d || settled !== m_settled ||
          inReady !== (!m_valid || outReady)) begin
        failures++;
        $display("[TB] FAIL backpressure cyc=%0d valid=%0b data=%h settled=%0b ready=%0b required %0b/%h/%0b/%0b",
                 i, outValid, dataOut, settled, inReady, m_valid, exp_d, m_settled,
                 !m_valid || outReady);
      end
      if (i == 1) held = dataOut;
      if (i >= 2 && i <= 5) begin
        checks++;
        if (inReady !== 1'b0 || dataOut !== held) begin
          failures++;
          $display("[TB] FAIL backpressure_hold cyc=%0d ready=%0b data=%h required 0/%h",
                   i, inReady, dataOut, held);
        end
      end
      model_clock(1'b1, int'(dataIn), outReady, acc);
      @(negedge clk);
    end
    inValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_gapped();
    bit acc;
    bit v;
    bit r;
    int n_acc;
    logic [WIDTH:0] exp_d;
    apply_reset();
    n_acc = 0;
    for (int i = 0; i < 200; i++) begin
      v        = ($urandom_range(0, 1) == 1);
      r        = ($urandom_range(0, 1) == 1);
      inValid  = v;
      dataIn   = WIDTH'($urandom_range(0, 255));
      outReady = r;
      #1;
      exp_d = m_data[WIDTH:0];
      checks++;
      if (outValid !== m_valid || dataOut !== exp_d || settled !== m_settled ||
          inReady !== (!m_valid || r)) begin
        failures++;
        $display("[TB] FAIL gapped cyc=%0d valid=%0b data=%h settled=%0b ready=%0b required %0b/%h/%0b/%0b",
                 i, outValid, dataOut, settled, inReady, m_valid, exp_d, m_settled, !m_valid || r);
      end
      if (n_acc == SETTLE_CNT - 1 || n_acc == SETTLE_CNT) begin
        checks++;
        if (settled !== (PRELOAD || n_acc >= SETTLE_CNT)) begin
          failures++;
          $display("[TB] FAIL gapped_settle accepts=%0d got=%0b required=%0b",
                   n_acc, settled, PRELOAD || n_acc >= SETTLE_CNT);
        end
      end
      model_clock(v, int'(dataIn), r, acc);
      if (acc) n_acc++;
      @(negedge clk);
    end
    inValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midstream();
    bit acc;
    apply_reset();
    inValid  = 1'b1;
    dataIn   = 8'd77;
    outReady = 1'b1;
    #1;
    model_clock(1'b1, 77, 1'b1, acc);
    @(negedge clk);
    inValid  = 1'b1;
    dataIn   = 8'd50;
    outReady = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (outValid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midreset_pending got=%0b required=1", outValid);
    end
    @(negedge clk);
    rst      = 1'b0;
    inValid  = 1'b0;
    outReady = 1'b1;
    model_reset();
    #1;
    checks++;
    if (outValid !== 1'b0 || settled !== 1'b0 || dataOut !== 9'd0) begin
      failures++;
      $display("[TB] FAIL midreset_clear valid=%0b settled=%0b data=%h required 0/0/000",
               outValid, settled, dataOut);
    end
    @(negedge clk);
    inValid = 1'b1;
    dataIn  = 8'd123;
    @(negedge clk);
    inValid = 1'b0;
    #1;
    checks++;
    if (outValid !== 1'b1 || dataOut !== (PRELOAD ? 9'd0 : 9'd123) || settled !== PRELOAD) begin
      failures++;
      $display("[TB] FAIL midreset_first valid=%0b data=%h settled=%0b required 1/%h/%0b",
               outValid, dataOut, settled, PRELOAD ? 9'd0 : 9'd123, PRELOAD);
    end
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    dataIn   = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_constant();
    test_extremes();
    test_backpressure();
    test_gapped();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
